// File: rtl/aes_128_arbiter_pkg.sv
// Shared constants and tag type for the two-requester AES-128 arbiter.
package aes_arb_pkg;
   localparam int AES_LATENCY_DEFAULT = 21;
   localparam int AES_BLOCK_W         = 128;
   localparam int AES_NUM_REQ         = 2;

   typedef struct packed {
      logic valid;
      logic id;
   } aes_tag_t;
endpackage

// File: rtl/aes_128_arbiter_if.sv
// Requester/result bundle of aes_128_arbiter; stat_* signals exist only with AES_ARB_STATS_EN.
interface aes_128_arbiter_if;
   import aes_arb_pkg::*;

   logic [AES_NUM_REQ-1:0]             req_valid;
   logic [AES_NUM_REQ-1:0]             req_ready;
   logic [AES_NUM_REQ*AES_BLOCK_W-1:0] req_state;
   logic [AES_NUM_REQ*AES_BLOCK_W-1:0] req_key;
   logic                               out_valid;
   logic                               out_id;
   logic [AES_BLOCK_W-1:0]             out;
   logic                               busy;
   logic [4:0]                         inflight;
`ifdef AES_ARB_STATS_EN
   logic [31:0]                        stat_done0;
   logic [31:0]                        stat_done1;
   logic [31:0]                        stat_conflict;

   modport slave (
      input  req_valid, req_state, req_key,
      output req_ready, out_valid, out_id, out, busy, inflight,
             stat_done0, stat_done1, stat_conflict
   );
   modport master (
      output req_valid, req_state, req_key,
      input  req_ready, out_valid, out_id, out, busy, inflight,
             stat_done0, stat_done1, stat_conflict
   );
`else
   modport slave (
      input  req_valid, req_state, req_key,
      output req_ready, out_valid, out_id, out, busy, inflight
   );
   modport master (
      output req_valid, req_state, req_key,
      input  req_ready, out_valid, out_id, out, busy, inflight
   );
`endif
endinterface

// File: rtl/aes_128.sv
// Fully pipelined AES-128 encryptor, no stall and no reset: input whitening stage plus
// two stages per round (SubBytes/ShiftRows with key expansion, then MixColumns/AddRoundKey).
module aes_128 (
   input  logic         clk,
   input  logic [127:0] state,
   input  logic [127:0] key,
   output logic [127:0] out
);
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box from the GF(2^8) inverse (a^254) followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++)
            r[127 - 8*(row + 4*c) -: 8] = sbox(s[127 - 8*(row + 4*((c + row) % 4)) -: 8]);
      return r;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   function automatic logic [7:0] rcon(input int n);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 1; i < n; i++) r = xtime(r);
      return r;
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
      w0 = k[127:96] ^ t;
      w1 = k[95:64]  ^ w0;
      w2 = k[63:32]  ^ w1;
      w3 = k[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   logic [127:0] st [11];
   logic [127:0] rk [10];
   logic [127:0] st0_reg;
   logic [127:0] rk0_reg;

   always_ff @(posedge clk) begin
      st0_reg <= state ^ key;
      rk0_reg <= key;
   end

   assign st[0] = st0_reg;
   assign rk[0] = rk0_reg;

   genvar gi;
   generate
      for (gi = 1; gi <= 10; gi++) begin : g_round
         logic [127:0] sub_reg;
         logic [127:0] key_reg;
         logic [127:0] st_reg;

         always_ff @(posedge clk) begin
            sub_reg <= sub_shift(st[gi-1]);
            key_reg <= next_key(rk[gi-1], rcon(gi));
            st_reg  <= ((gi == 10) ? sub_reg : mix(sub_reg)) ^ key_reg;
         end

         assign st[gi] = st_reg;

         if (gi < 10) begin : g_key
            logic [127:0] rk_reg;
            always_ff @(posedge clk) rk_reg <= key_reg;
            assign rk[gi] = rk_reg;
         end
      end
   endgenerate

   assign out = st[10];
endmodule

// File: rtl/aes_128_arbiter_tag_pipe.sv
// {valid, id} delay line of DEPTH stages; every stage clears asynchronously on reset.
module aes_tag_pipe
   import aes_arb_pkg::*;
#(
   parameter int DEPTH = AES_LATENCY_DEFAULT
) (
   input  logic     clk,
   input  logic     rst_n,
   input  aes_tag_t load_tag,
   output aes_tag_t tag
);
   aes_tag_t stage [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         aes_tag_t stage_reg;
         aes_tag_t stage_next;

         if (gi == 0) begin : g_head
            assign stage_next = load_tag;
         end else begin : g_body
            assign stage_next = stage[gi-1];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) stage_reg <= '0;
            else        stage_reg <= stage_next;
         end

         assign stage[gi] = stage_reg;
      end
   endgenerate

   assign tag = stage[DEPTH-1];
endmodule

// File: rtl/aes_128_arbiter.sv
// Round-robin sharing of one pipelined aes_128 between two requesters with ID-tagged results.
// Define AES_ARB_STATS_EN to add saturating completion/conflict counters.
module aes_128_arbiter
   import aes_arb_pkg::*;
#(
   parameter int AES_LATENCY = AES_LATENCY_DEFAULT,
   parameter int NUM_REQ     = AES_NUM_REQ
) (
   input logic              clk,
   input logic              rst_n,
   aes_128_arbiter_if.slave bus
);
   logic [NUM_REQ-1:0]     valid;
   logic                   grant_any;
   logic                   grant_id;
   logic                   prio_reg;
   logic                   prio_next;
   logic [4:0]             inflight_reg;
   logic [4:0]             inflight_next;
   logic [AES_BLOCK_W-1:0] core_state;
   logic [AES_BLOCK_W-1:0] core_key;
   aes_tag_t               tag_load;
   aes_tag_t               tag_done;

   // Nothing is granted while reset is held, so req_ready reads 0 then.
   assign valid = bus.req_valid & {NUM_REQ{rst_n}};

   always_comb begin
      grant_any = |valid;
      grant_id  = (&valid) ? prio_reg : valid[1];
      prio_next = prio_reg;
      if (&valid)         prio_next = ~prio_reg;
      else if (grant_any) prio_next = ~grant_id;
   end

   assign bus.req_ready = {grant_any & grant_id, grant_any & ~grant_id};

   // Idle cycles feed zeros so core toggle activity does not depend on stale requester data.
   assign core_state = !grant_any ? '0 :
                       grant_id   ? bus.req_state[2*AES_BLOCK_W-1:AES_BLOCK_W] :
                                    bus.req_state[AES_BLOCK_W-1:0];
   assign core_key   = !grant_any ? '0 :
                       grant_id   ? bus.req_key[2*AES_BLOCK_W-1:AES_BLOCK_W] :
                                    bus.req_key[AES_BLOCK_W-1:0];

   aes_128 u_core (
      .clk   (clk),
      .state (core_state),
      .key   (core_key),
      .out   (bus.out)
   );

   assign tag_load = '{valid: grant_any, id: grant_id};

   aes_tag_pipe #(.DEPTH(AES_LATENCY)) u_tag_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_tag (tag_load),
      .tag      (tag_done)
   );

   assign bus.out_valid = tag_done.valid;
   assign bus.out_id    = tag_done.id;

   always_comb begin
      inflight_next = inflight_reg;
      if (grant_any && !tag_done.valid)      inflight_next = inflight_reg + 5'd1;
      else if (!grant_any && tag_done.valid) inflight_next = inflight_reg - 5'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_reg     <= 1'b0;
         inflight_reg <= '0;
      end else begin
         prio_reg     <= prio_next;
         inflight_reg <= inflight_next;
      end
   end

   assign bus.inflight = inflight_reg;
   assign bus.busy     = (inflight_reg != 5'd0);

`ifdef AES_ARB_STATS_EN
   logic [31:0] done0_reg;
   logic [31:0] done1_reg;
   logic [31:0] conflict_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done0_reg    <= '0;
         done1_reg    <= '0;
         conflict_reg <= '0;
      end else begin
         if (tag_done.valid && !tag_done.id && done0_reg != 32'hFFFF_FFFF)
            done0_reg <= done0_reg + 32'd1;
         if (tag_done.valid && tag_done.id && done1_reg != 32'hFFFF_FFFF)
            done1_reg <= done1_reg + 32'd1;
         if ((&valid) && conflict_reg != 32'hFFFF_FFFF)
            conflict_reg <= conflict_reg + 32'd1;
      end
   end

   assign bus.stat_done0    = done0_reg;
   assign bus.stat_done1    = done1_reg;
   assign bus.stat_conflict = conflict_reg;
`endif
endmodule

// File: tb/tb_aes_128_arbiter.sv
// Directed bench for aes_128_arbiter: queue-based job model checked every cycle plus phase literals.
module tb_aes_128_arbiter;
   import aes_arb_pkg::*;

   localparam int           LAT  = 21;
   localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_128_arbiter_if bus ();

   aes_128_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int due;
      bit id;
   } job_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   job_t jobs[$];
   bit   prio_m;
   bit   g_any, g_id, both, due_now;

   // Observations of the DUT collected per phase for the literal checks.
   int   pulses, max_inflight, first_out_cyc, last_out_cyc;
   bit   grant_log[$];
   bit   out_id_log[$];
   logic [127:0] last_out;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_req_ready", bus.req_ready, 0);
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_out_id", bus.out_id, 0);
         chk("rst_inflight", bus.inflight, 0);
         chk("rst_busy", bus.busy, 0);
         jobs.delete();
         prio_m = 1'b0;
      end else begin
         both  = bus.req_valid == 2'b11;
         g_any = bus.req_valid != 2'b00;
         if (both)                 g_id = prio_m;
         else if (bus.req_valid[0]) g_id = 1'b0;
         else                       g_id = 1'b1;

         chk("req_ready", bus.req_ready, g_any ? (g_id ? 2'b10 : 2'b01) : 2'b00);
         chk("inflight", bus.inflight, jobs.size());
         chk("busy", bus.busy, jobs.size() != 0);

         due_now = (jobs.size() > 0) && (jobs[0].due == cyc);
         chk("out_valid", bus.out_valid, due_now);
         if (due_now) begin
            chk("out_id", bus.out_id, jobs[0].id);
            chk("out_data", bus.out, jobs[0].id ? CT1 : CT0);
            jobs.pop_front();
         end

         if (bus.out_valid) begin
            $display("result cycle %0d id %0d data %h", cyc, bus.out_id, bus.out);
            pulses++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            last_out     = bus.out;
            out_id_log.push_back(bus.out_id);
         end
         if (int'(bus.inflight) > max_inflight) max_inflight = int'(bus.inflight);
         if (bus.req_ready == 2'b01) grant_log.push_back(1'b0);
         if (bus.req_ready == 2'b10) grant_log.push_back(1'b1);

         if (g_any) begin
            jobs.push_back('{due: cyc + LAT, id: g_id});
            prio_m = both ? ~prio_m : ~g_id;
         end
      end
   end

   task automatic drive(input logic [1:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         bus.req_valid = v;
         @(posedge clk);
         #1;
      end
      bus.req_valid = 2'b00;
   endtask

   task automatic clear_log();
      pulses        = 0;
      max_inflight  = 0;
      first_out_cyc = -1;
      last_out_cyc  = -1;
      grant_log.delete();
      out_id_log.delete();
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   int start;
   bit ok;

   initial begin
      bus.req_valid = 2'b00;
      bus.req_state = {PT1, PT0};
      bus.req_key   = {KEY1, KEY0};
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle after reset
      clear_log();
      drive(2'b00, 30);
      chk("idle_pulses", pulses, 0);
      chk("idle_max_inflight", max_inflight, 0);
      chk("idle_busy", bus.busy, 0);

      // Single FIPS-197 job from requester 0
      clear_log();
      start = cyc;
      drive(2'b01, 1);
      drive(2'b00, 25);
      chk("single_pulses", pulses, 1);
      chk("single_latency", first_out_cyc - start, 21);
      chk("single_id", (out_id_log.size() == 1) ? out_id_log[0] : 1'b1, 0);
      chk("single_ct", last_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

      // Both requesters for 10 cycles from a fresh prio
      pulse_reset();
      clear_log();
      start = cyc;
      drive(2'b11, 10);
      drive(2'b00, 25);
      ok = (grant_log.size() == 10) && (out_id_log.size() == 10);
      for (int k = 0; k < grant_log.size() && k < out_id_log.size(); k++)
         if (grant_log[k] != k[0] || out_id_log[k] != k[0]) ok = 1'b0;
      chk("both_alternate", ok, 1);
      chk("both_pulses", pulses, 10);
      chk("both_first_out", first_out_cyc - start, 21);
      chk("both_last_out", last_out_cyc - start, 30);
      chk("both_peak_inflight", max_inflight, 10);
`ifdef AES_ARB_STATS_EN
      chk("stat_conflict", bus.stat_conflict, 10);
      chk("stat_done0", bus.stat_done0, 5);
      chk("stat_done1", bus.stat_done1, 5);
`endif

      // Continuous requester-1 stream
      clear_log();
      drive(2'b10, 50);
      drive(2'b00, 25);
      chk("stream_pulses", pulses, 50);
      chk("stream_peak_inflight", max_inflight, 21);

      // Reset with 7 jobs in flight
      clear_log();
      drive(2'b01, 7);
      drive(2'b00, 3);
      chk("pre_rst_inflight", bus.inflight, 7);
      bus.req_valid = 2'b11;
      rst_n         = 1'b0;
      #1;
      chk("async_rst_ready", bus.req_ready, 0);
      chk("async_rst_out_valid", bus.out_valid, 0);
      chk("async_rst_inflight", bus.inflight, 0);
      chk("async_rst_busy", bus.busy, 0);
      repeat (2) @(posedge clk);
      #1;
      bus.req_valid = 2'b00;
      rst_n         = 1'b1;
      clear_log();
      drive(2'b00, 30);
      chk("dropped_pulses", pulses, 0);

      // Requester 1 alone, then requester 0 joins
      clear_log();
      drive(2'b10, 3);
      drive(2'b11, 1);
      drive(2'b00, 25);
      chk("join_grant_count", grant_log.size(), 4);
      chk("join_grant", (grant_log.size() == 4) ? grant_log[3] : 1'b1, 0);
      chk("join_pulses", pulses, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
